// File: rtl/ws2812_rx.sv
// WS2812 single-wire LED data receiver: decodes 24-bit GRB pixels, flags frame latch and protocol errors.
// Define WS2812_RX_FWD_EN to enable daisy-chain forwarding of the data line on dout.
module ws2812_rx #(
    parameter int T_THRESH  = 30,
    parameter int MIN_HIGH  = 8,
    parameter int MAX_HIGH  = 60,
    parameter int RESET_CYC = 2500,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic             frame_done,
    output logic             err,
    output logic             dout
);

    localparam int LOW_W  = $clog2(RESET_CYC + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 1);

    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(RESET_CYC);
    localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(RESET_CYC - 1);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(T_THRESH);

    typedef enum logic [1:0] {
        WAIT_RST,
        READY,
        HIGH
    } state_t;

    state_t state, state_d;

    logic              sync1, ds, ds_q;
    logic              rise, fall;
    logic [LOW_W-1:0]  low_cnt;
    logic [HIGH_W-1:0] high_cnt;
    logic [4:0]        bit_cnt;
    logic [23:0]       shift;
    logic [IDX_W-1:0]  next_idx;
    logic              have_pix;

    logic low_hit;
    logic start_high;
    logic take_bit;
    logic bit_val;
    logic latch;
    logic frame_done_d;
    logic err_d;
    logic pix_done;

    // Two-flop synchronizer plus one registered copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            ds    <= 1'b0;
            ds_q  <= 1'b0;
        end else begin
            sync1 <= din;
            ds    <= sync1;
            ds_q  <= ds;
        end
    end

    assign rise     = ds & ~ds_q;
    assign fall     = ~ds & ds_q;
    // Fires once per low stretch: the counter saturates at RESET_CYC.
    assign low_hit  = ~ds && (low_cnt == LOW_LAST);
    assign pix_done = take_bit && (bit_cnt == 5'd23);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_RST;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state;
        start_high   = 1'b0;
        take_bit     = 1'b0;
        bit_val      = 1'b0;
        latch        = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        case (state)
            WAIT_RST: begin
                if (low_hit) begin
                    latch   = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                if (rise) begin
                    start_high = 1'b1;
                    state_d    = HIGH;
                end else if (low_hit) begin
                    latch        = 1'b1;
                    frame_done_d = have_pix;
                    err_d        = (bit_cnt != 5'd0);
                end
            end
            HIGH: begin
                if (fall) begin
                    if (high_cnt < HIGH_MIN) begin
                        err_d   = 1'b1;
                        state_d = WAIT_RST;
                    end else begin
                        take_bit = 1'b1;
                        bit_val  = (high_cnt >= HIGH_ONE);
                        state_d  = READY;
                    end
                end else if (high_cnt >= HIGH_MAX) begin
                    // ds is still high here: the pulse has outlived the legal maximum.
                    err_d   = 1'b1;
                    state_d = WAIT_RST;
                end
            end
            default: state_d = WAIT_RST;
        endcase
    end

    // high_cnt holds the number of ds-high cycles so far, the edge cycle included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            if (ds) begin
                low_cnt <= '0;
            end else if (low_cnt != LOW_MAX) begin
                low_cnt <= low_cnt + 1'b1;
            end
            if (start_high) begin
                high_cnt <= HIGH_W'(1);
            end else if (state == HIGH && ds && high_cnt != HIGH_MAX) begin
                high_cnt <= high_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            shift      <= '0;
            next_idx   <= '0;
            have_pix   <= 1'b0;
            pix_data   <= '0;
            pix_index  <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= frame_done_d;
            err        <= err_d;
            if (latch) begin
                bit_cnt   <= '0;
                next_idx  <= '0;
                pix_index <= '0;
                have_pix  <= 1'b0;
            end else if (take_bit) begin
                shift <= {shift[22:0], bit_val};
                if (pix_done) begin
                    bit_cnt   <= '0;
                    pix_data  <= {shift[22:0], bit_val};
                    pix_index <= next_idx;
                    next_idx  <= next_idx + 1'b1;
                    have_pix  <= 1'b1;
                    pix_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

`ifdef WS2812_RX_FWD_EN
    logic fwd;

    // Once this receiver owns its first pixel, the rest of the frame belongs downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd <= 1'b0;
        end else if (latch) begin
            fwd <= 1'b0;
        end else if (pix_done) begin
            fwd <= 1'b1;
        end
    end

    assign dout = ds & fwd;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: randomized pulse lengths checked against a rule-based model.
// Forward-output checks follow WS2812_RX_FWD_EN when it is defined for the build.
module tb_ws2812_rx;

    localparam int T_THRESH  = 30;
    localparam int MIN_HIGH  = 8;
    localparam int MAX_HIGH  = 60;
    localparam int RESET_CYC = 2500;
    localparam int IDX_W     = 3;
    localparam int GAP       = 2600;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic [23:0]      pix_data;
    logic             pix_valid;
    logic [IDX_W-1:0] pix_index;
    logic             frame_done;
    logic             err;
    logic             dout;

    ws2812_rx #(
        .T_THRESH (T_THRESH),
        .MIN_HIGH (MIN_HIGH),
        .MAX_HIGH (MAX_HIGH),
        .RESET_CYC(RESET_CYC),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_index (pix_index),
        .frame_done(frame_done),
        .err       (err),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // din delayed by the two synchronizer stages, as seen just after each edge.
    logic h1 = 1'b0, h2 = 1'b0;
    always @(posedge clk) begin
        h1 <= din;
        h2 <= h1;
    end

    logic [23:0] pv_data[$];
    int          pv_idx[$];
    int          pv_cyc[$];
    int          fd_cyc[$];
    int          err_cyc[$];
    bit          mon_en    = 1'b0;
    int          dout_mode = 0;
    int          dout_bad  = 0;
    int          both_bad  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid) begin
                pv_data.push_back(pix_data);
                pv_idx.push_back(int'(pix_index));
                pv_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (err) err_cyc.push_back(cyc);
            if (pix_valid && err) both_bad++;
            if (dout_mode == 1 && dout !== 1'b0) dout_bad++;
            if (dout_mode == 2 && dout !== h2) dout_bad++;
        end
    end

    task automatic clear_mon();
        pv_data.delete();
        pv_idx.delete();
        pv_cyc.delete();
        fd_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        hold(hi);
        din = 1'b0;
        last_fall = cyc;
        hold(lo);
    endtask

    // Sends the top nbits of px MSB-first; decoded is what the protocol rule makes of the highs sent.
    task automatic send_bits(input logic [23:0] px, input int nbits, input bit rnd,
                             output logic [23:0] decoded);
        int hi;
        int lo;
        decoded = '0;
        for (int i = 23; i > 23 - nbits; i--) begin
            if (px[i]) hi = rnd ? int'($urandom_range(MAX_HIGH, T_THRESH)) : 40;
            else       hi = rnd ? int'($urandom_range(T_THRESH - 1, MIN_HIGH)) : 20;
            lo = rnd ? int'($urandom_range(20, 2)) : (px[i] ? 22 : 42);
            decoded = {decoded[22:0], (hi >= T_THRESH)};
            pulse(hi, lo);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        din   = 1'b0;
        #1;
        n_checks++;
        if (pix_data !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_pix_data: got %h expected 000000", pix_data);
        end
        n_checks++;
        if (pix_index !== '0) begin
            n_fail++;
            $display("FAIL reset_pix_index: got %0d expected 0", pix_index);
        end
        n_checks++;
        if ({pix_valid, frame_done, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 000", {pix_valid, frame_done, err});
        end
        n_checks++;
        if (dout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dout: got %b expected 0", dout);
        end
        hold(3);
        reset  = 1'b1;
        mon_en = 1'b1;
`ifndef WS2812_RX_FWD_EN
        dout_mode = 1;
`endif
        hold(2);
    endtask

    task automatic test_basic();
        logic [23:0] exp_px;
        clear_mon();
        hold(GAP);
        send_bits(24'h00FF81, 24, 1'b0, exp_px);
        n_checks++;
        if (pv_data.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pixels expected 1", pv_data.size());
        end else begin
            n_checks += 3;
            if (pv_data[0] !== 24'h00FF81) begin
                n_fail++;
                $display("FAIL basic_data: got %h expected 00ff81", pv_data[0]);
            end
            if (pv_idx[0] != 0) begin
                n_fail++;
                $display("FAIL basic_index: got %0d expected 0", pv_idx[0]);
            end
            // Two synchronizer stages, one edge-detect cycle, then the registered strobe.
            if (pv_cyc[0] != last_fall + 3) begin
                n_fail++;
                $display("FAIL basic_latency: got cycle %0d expected %0d", pv_cyc[0], last_fall + 3);
            end
        end
        hold(GAP);
        n_checks++;
        if (fd_cyc.size() != 1 || err_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL basic_latch: got frame_done=%0d err=%0d expected 1 and 0",
                     fd_cyc.size(), err_cyc.size());
        end
    endtask

    task automatic test_frame();
        logic [23:0] px[3];
        logic [23:0] dec;
        px[0] = 24'h111111;
        px[1] = 24'h222222;
        px[2] = 24'h333333;
        clear_mon();
        for (int p = 0; p < 3; p++) send_bits(px[p], 24, 1'b0, dec);
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 3) begin
            n_fail++;
            $display("FAIL frame_count: got %0d pixels expected 3", pv_data.size());
        end else begin
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if (pv_data[p] !== px[p] || pv_idx[p] != p) begin
                    n_fail++;
                    $display("FAIL frame_pixel%0d: got %h idx %0d expected %h idx %0d",
                             p, pv_data[p], pv_idx[p], px[p], p);
                end
            end
            n_checks++;
            if (fd_cyc.size() != 1 || fd_cyc[0] <= pv_cyc[2]) begin
                n_fail++;
                $display("FAIL frame_done: got %0d strobes expected 1 after last pixel", fd_cyc.size());
            end
        end
        n_checks++;
        if (err_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL frame_err: got %0d errors expected 0", err_cyc.size());
        end
    endtask

    task automatic test_partial();
        logic [23:0] dec;
        clear_mon();
        send_bits(24'($urandom), 12, 1'b1, dec);
        hold(GAP);
        n_checks++;
        if (err_cyc.size() != 1 || pv_data.size() != 0 || fd_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL partial: got err=%0d pix=%0d frame=%0d expected 1 0 0",
                     err_cyc.size(), pv_data.size(), fd_cyc.size());
        end
    endtask

    task automatic test_long_high();
        int start;
        logic [23:0] px;
        logic [23:0] dec;
        clear_mon();
        start = cyc;
        din = 1'b1;
        hold(70);
        din = 1'b0;
        hold(30);
        send_bits(24'($urandom), 24, 1'b1, dec);
        n_checks++;
        // Error lands on the 61st synchronized high cycle, two cycles behind din.
        if (err_cyc.size() != 1 || err_cyc[0] != start + MAX_HIGH + 3) begin
            n_fail++;
            $display("FAIL long_high_err: got %0d errors first at %0d expected 1 at %0d",
                     err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1, start + MAX_HIGH + 3);
        end
        n_checks++;
        if (pv_data.size() != 0) begin
            n_fail++;
            $display("FAIL long_high_ignored: got %0d pixels expected 0", pv_data.size());
        end
        hold(GAP);
        px = 24'($urandom);
        send_bits(px, 24, 1'b1, dec);
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 1 || pv_data[0] !== dec || pv_idx[0] != 0 || err_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL long_high_recover: got pix=%0d err=%0d expected one pixel %h idx 0",
                     pv_data.size(), err_cyc.size(), dec);
        end
    endtask

    task automatic test_thresholds();
        int hi;
        clear_mon();
        pulse(5, GAP);
        n_checks++;
        if (err_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL short_5: got %0d errors expected 1", err_cyc.size());
        end
        pulse(MIN_HIGH - 1, GAP);
        n_checks++;
        if (err_cyc.size() != 2 || pv_data.size() != 0 || fd_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL short_min: got err=%0d pix=%0d frame=%0d expected 2 0 0",
                     err_cyc.size(), pv_data.size(), fd_cyc.size());
        end
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0:       hi = T_THRESH;
                1:       hi = T_THRESH - 1;
                2:       hi = MIN_HIGH;
                default: hi = MAX_HIGH;
            endcase
            pulse(hi, 25);
        end
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 1 || pv_data[0] !== 24'h999999) begin
            n_fail++;
            $display("FAIL threshold_bits: got %0d pixels first %h expected 999999",
                     pv_data.size(), (pv_data.size() > 0) ? pv_data[0] : 24'h0);
        end
        n_checks++;
        if (err_cyc.size() != 2 || fd_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL threshold_latch: got err=%0d frame=%0d expected 2 1",
                     err_cyc.size(), fd_cyc.size());
        end
    endtask

    task automatic test_random_frames();
        logic [23:0] exp_q[$];
        logic [23:0] dec;
        int n;
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            exp_q.delete();
            n = int'($urandom_range(3, 1));
            for (int p = 0; p < n; p++) begin
                send_bits(24'($urandom), 24, 1'b1, dec);
                exp_q.push_back(dec);
            end
            hold(GAP);
            n_checks++;
            if (pv_data.size() != n || fd_cyc.size() != 1 || err_cyc.size() != 0) begin
                n_fail++;
                $display("FAIL random%0d_counts: got pix=%0d frame=%0d err=%0d expected %0d 1 0",
                         f, pv_data.size(), fd_cyc.size(), err_cyc.size(), n);
            end else begin
                for (int p = 0; p < n; p++) begin
                    n_checks++;
                    if (pv_data[p] !== exp_q[p] || pv_idx[p] != p) begin
                        n_fail++;
                        $display("FAIL random%0d_pixel%0d: got %h idx %0d expected %h idx %0d",
                                 f, p, pv_data[p], pv_idx[p], exp_q[p], p);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [23:0] exp_q[$];
        logic [23:0] dec;
        clear_mon();
        for (int p = 0; p < 10; p++) begin
            send_bits(24'($urandom), 24, 1'b0, dec);
            exp_q.push_back(dec);
        end
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 10 || err_cyc.size() != 0 || fd_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL wrap_counts: got pix=%0d err=%0d frame=%0d expected 10 0 1",
                     pv_data.size(), err_cyc.size(), fd_cyc.size());
        end else begin
            for (int p = 0; p < 10; p++) begin
                n_checks++;
                if (pv_data[p] !== exp_q[p] || pv_idx[p] != p % (1 << IDX_W)) begin
                    n_fail++;
                    $display("FAIL wrap_pixel%0d: got %h idx %0d expected %h idx %0d",
                             p, pv_data[p], pv_idx[p], exp_q[p], p % (1 << IDX_W));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] dec;
        logic [23:0] px;
        clear_mon();
        send_bits(24'($urandom), 12, 1'b1, dec);
        reset = 1'b0;
        din   = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, frame_done, err} !== 3'b000 || pix_index !== '0 || pix_data !== 24'h0) begin
            n_fail++;
            $display("FAIL midframe_reset_state: got strobes %b idx %0d data %h expected all zero",
                     {pix_valid, frame_done, err}, pix_index, pix_data);
        end
        hold(3);
        reset = 1'b1;
        hold(50);
        send_bits(24'($urandom), 24, 1'b1, dec);
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 0 || err_cyc.size() != 0 || fd_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL midframe_no_strobe: got pix=%0d err=%0d frame=%0d expected 0 0 0",
                     pv_data.size(), err_cyc.size(), fd_cyc.size());
        end
        px = 24'($urandom);
        send_bits(px, 24, 1'b1, dec);
        hold(GAP);
        n_checks++;
        if (pv_data.size() != 1 || pv_data[0] !== dec || pv_idx[0] != 0) begin
            n_fail++;
            $display("FAIL midframe_recover: got %0d pixels expected one %h idx 0", pv_data.size(), dec);
        end
    endtask

    task automatic test_forward();
        logic [23:0] dec;
`ifdef WS2812_RX_FWD_EN
        dout_mode = 1;
        send_bits(24'($urandom), 24, 1'b1, dec);
        dout_mode = 2;
        send_bits(24'($urandom), 24, 1'b1, dec);
        dout_mode = 0;
        hold(GAP);
`else
        send_bits(24'($urandom), 24, 1'b1, dec);
        send_bits(24'($urandom), 24, 1'b1, dec);
        hold(GAP);
`endif
        n_checks++;
        if (dout_bad != 0) begin
            n_fail++;
            $display("FAIL forward_dout: got %0d mismatching cycles expected 0", dout_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_partial();
        test_long_high();
        test_thresholds();
        test_random_frames();
        test_wrap();
        test_reset_midframe();
        test_forward();
        n_checks++;
        if (both_bad != 0) begin
            n_fail++;
            $display("FAIL err_with_valid: got %0d overlapping cycles expected 0", both_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 The block SHALL have parameter T_THRESH, default 30, meaning high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-002 The block SHALL have parameter MIN_HIGH, default 8, meaning the shortest legal high pulse in cycles.
REQ-003 The block SHALL have parameter MAX_HIGH, default 60, meaning the longest legal high pulse in cycles.
REQ-004 The block SHALL have parameter RESET_CYC, default 2500, meaning the low time in cycles that marks reset/latch (50 us at 50 MHz).
REQ-005 The block SHALL have parameter IDX_W, default 8, meaning the width of the pixel index.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port din, input, 1 bit: the asynchronous single-wire LED data line.
REQ-009 The block SHALL have port pix_data, output, 24 bits: the last decoded pixel in GRB order, G in [23:16].
REQ-010 The block SHALL have port pix_valid, output, 1 bit: a one-cycle strobe that pix_data is new.
REQ-011 The block SHALL have port pix_index, output, IDX_W bits: the index of the pixel in pix_data, 0 for the first pixel of a frame.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle strobe at the latch of a frame with at least one pixel.
REQ-013 The block SHALL have port err, output, 1 bit: a one-cycle strobe on a protocol violation.
REQ-014 The block SHALL have port dout, output, 1 bit: the daisy-chain forward output (see Configuration).

Function
REQ-015 din SHALL pass through a 2-flop synchronizer; all cycle references below are to the synchronized signal ds, with edges detected against a registered copy of ds.
REQ-016 The FSM SHALL have states WAIT_RST, READY and HIGH.
REQ-017 WAIT_RST: low counter increments while ds=0 and clears on ds=1; on reaching RESET_CYC the FSM goes to READY with bit_cnt=0 and pix_index=0.
REQ-018 READY: the low counter runs while ds=0; a rising edge clears the high counter and goes to HIGH.
REQ-019 READY low count reaching RESET_CYC: if pixels were decoded in the frame, frame_done pulses; if bit_cnt!=0, err pulses and the partial pixel is discarded; bit_cnt, pix_index and the pixel count clear; the FSM stays in READY.
REQ-020 HIGH, falling edge with high count < MIN_HIGH: err pulses, the bit is discarded, the FSM goes to WAIT_RST.
REQ-021 HIGH, falling edge otherwise: bit = (count >= T_THRESH), shifted MSB-first into the shift register; bit_cnt increments; the FSM goes to READY.
REQ-022 HIGH count exceeding MAX_HIGH while ds=1: err pulses, the FSM goes to WAIT_RST, and the partial pixel is discarded.
REQ-023 On the 24th bit, pix_data and pix_index SHALL update and pix_valid SHALL pulse exactly one cycle after the falling edge is detected; bit_cnt clears.
REQ-024 pix_index SHALL increment after each pix_valid and wrap from 2^IDX_W-1 to 0 without error.
REQ-025 Counters SHALL saturate at their terminal value and never wrap.
REQ-026 pix_data SHALL hold its value between strobes.
REQ-027 err and pix_valid SHALL never assert in the same cycle.

Reset
REQ-028 On reset low: FSM=WAIT_RST; synchronizer flops=0; all counters=0; pix_data=0; pix_index=0; pix_valid, frame_done, err, dout=0.
REQ-029 Reset assertion mid-frame SHALL abort decode without any strobe.
REQ-030 After reset release, a full RESET_CYC low SHALL be seen before any bit is accepted.

Configuration
REQ-031 Macro WS2812_RX_FWD_EN, defined: dout = ds once the frame's first 24 bits are consumed, until the next latch; otherwise dout=0 (WS2812 chain behaviour).
REQ-032 Macro WS2812_RX_FWD_EN, undefined: dout is tied to 0 and the forward logic is absent.

Verification
REQ-033 Bench: reset, 2600 low, bits of 0x00FF81 (1=40 high/22 low, 0=20 high/42 low) -> one pix_valid, pix_data=0x00FF81, pix_index=0.
REQ-034 Bench: 3 pixels 0x111111, 0x222222, 0x333333, then 2600 low -> indices 0,1,2 in order, then a single frame_done.
REQ-035 Bench: 12 bits, then 2600 low -> err pulse, no pix_valid, no frame_done.
REQ-036 Bench: high held 70 cycles -> err at cycle 61 of high; following bits ignored until 2500 low.
REQ-037 Bench: high of 5 cycles -> err; high of exactly 30 -> bit 1; high of 29 -> bit 0.
REQ-038 Bench, WS2812_RX_FWD_EN defined: 2 pixels -> dout=0 during pixel 0 and equal to din delayed 2 cycles during pixel 1; undefined -> dout=0 throughout.
